// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the Memory macro.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if;
    logic        p_req;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    logic        p_gnt;
    logic [31:0] p_rdata;
    logic        p_stall;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic        d_lock;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    modport slave (
        input  p_req, p_addr, p_wdata, p_we,
        input  d_req, d_addr, d_wdata, d_we, d_lock,
        input  mem_rdata,
        output p_gnt, p_rdata, p_stall,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output p_req, p_addr, p_wdata, p_we,
        output d_req, d_addr, d_wdata, d_we, d_lock,
        output mem_rdata,
        input  p_gnt, p_rdata, p_stall,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline MEM stage vs. debug/DMA, with
// starvation guard for debug and bounded locked debug bursts.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_TRIG = SW'(STARVE_LIMIT - 1);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);

    typedef enum logic [0:0] {
        P_OWN = 1'b0,
        D_OWN = 1'b1
    } own_e;

    own_e            state_q, state_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            p_gnt_s, d_gnt_s;

    // Grant decode; the owner wins a tie, and reset kills both grants at once.
    always_comb begin
        p_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst_n) begin
            case (state_q)
                P_OWN: begin
                    p_gnt_s = bus.p_req;
                    d_gnt_s = bus.d_req & ~bus.p_req;
                end
                D_OWN: begin
                    d_gnt_s = bus.d_req;
                    p_gnt_s = bus.p_req & ~bus.d_req;
                end
                default: begin
                    p_gnt_s = 1'b0;
                    d_gnt_s = 1'b0;
                end
            endcase
        end else begin
            p_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Ownership and burst-length bookkeeping; a burst started from P_OWN has already used beat 1.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            P_OWN: begin
                if (d_gnt_s & bus.d_lock) begin
                    state_d     = D_OWN;
                    burst_cnt_d = BURST_ONE;
                end else if (bus.d_req & ~d_gnt_s & (starve_cnt_q == STARVE_TRIG)) begin
                    state_d     = D_OWN;
                    burst_cnt_d = {BW{1'b0}};
                end else begin
                    state_d     = P_OWN;
                    burst_cnt_d = {BW{1'b0}};
                end
            end
            D_OWN: begin
                if (~bus.d_req | (d_gnt_s & ~bus.d_lock) | (d_gnt_s & (burst_cnt_q >= BURST_LAST))) begin
                    state_d     = P_OWN;
                    burst_cnt_d = {BW{1'b0}};
                end else if (d_gnt_s) begin
                    state_d     = D_OWN;
                    burst_cnt_d = burst_cnt_q + BURST_ONE;
                end else begin
                    state_d     = D_OWN;
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = P_OWN;
                burst_cnt_d = {BW{1'b0}};
            end
        endcase
    end

    // Starvation counter and debug read-data capture.
    always_comb begin
        starve_cnt_d = {SW{1'b0}};
        d_rvalid_d   = 1'b0;
        d_rdata_d    = d_rdata_q;
        if (bus.d_req & ~d_gnt_s) begin
            starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? starve_cnt_q : starve_cnt_q + STARVE_ONE;
        end else begin
            starve_cnt_d = {SW{1'b0}};
        end
        if (d_gnt_s & ~bus.d_we) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus.mem_rdata;
        end else begin
            d_rvalid_d = 1'b0;
            d_rdata_d  = d_rdata_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= P_OWN;
            starve_cnt_q <= {SW{1'b0}};
            burst_cnt_q  <= {BW{1'b0}};
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.p_gnt     = p_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.p_stall   = bus.p_req & ~p_gnt_s;
    assign bus.p_rdata   = bus.mem_rdata;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = d_gnt_s ? bus.d_addr  : bus.p_addr;
    assign bus.mem_wdata = d_gnt_s ? bus.d_wdata : bus.p_wdata;
    assign bus.mem_wen   = (p_gnt_s & bus.p_we) | (d_gnt_s & bus.d_we);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory model serves the DUT, a behavioural
// reference checks every cycle, and hand-computed expectations pin key scenarios.
module tb_dmem_arbiter;
    localparam int SL = 4;
    localparam int MB = 8;

    logic clk;
    logic rst_n;
    dmem_arbiter_if ifc ();

    dmem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro stand-in: combinational read, write at the rising edge.
    logic [31:0] mem_arr [0:255];
    assign ifc.mem_rdata = mem_arr[ifc.mem_addr[9:2]];
    always @(posedge clk) begin
        if (ifc.mem_wen) mem_arr[ifc.mem_addr[9:2]] <= ifc.mem_wdata;
    end

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [31:0] mdl_mem [0:255];
    bit          m_dbg    = 1'b0;
    int          m_waited = 0;
    int          m_beats  = 0;
    bit          m_rv     = 1'b0;
    logic [31:0] m_rd     = 32'h0;

    always @(negedge clk) begin
        bit          epg, edg, ewen, erv;
        logic [31:0] eaddr, ewdata, erd;
        if (started) begin
            if (!rst_n) begin
                epg = 1'b0; edg = 1'b0; erv = 1'b0; erd = 32'h0;
            end else begin
                epg = m_dbg ? (ifc.p_req & ~ifc.d_req) : ifc.p_req;
                edg = m_dbg ? ifc.d_req : (ifc.d_req & ~ifc.p_req);
                erv = m_rv;
                erd = m_rd;
            end
            ewen   = (epg & ifc.p_we) | (edg & ifc.d_we);
            eaddr  = edg ? ifc.d_addr : ifc.p_addr;
            ewdata = edg ? ifc.d_wdata : ifc.p_wdata;
            chk("m_p_gnt", {31'b0, ifc.p_gnt}, {31'b0, epg});
            chk("m_d_gnt", {31'b0, ifc.d_gnt}, {31'b0, edg});
            chk("m_p_stall", {31'b0, ifc.p_stall}, {31'b0, ifc.p_req & ~epg});
            chk("m_mem_wen", {31'b0, ifc.mem_wen}, {31'b0, ewen});
            chk("m_mem_addr", ifc.mem_addr, eaddr);
            chk("m_mem_wdata", ifc.mem_wdata, ewdata);
            chk("m_d_rvalid", {31'b0, ifc.d_rvalid}, {31'b0, erv});
            chk("m_d_rdata", ifc.d_rdata, erd);
            if (epg && !ifc.p_we) chk("m_p_rdata", ifc.p_rdata, mdl_mem[ifc.p_addr[9:2]]);

            if (!rst_n) begin
                m_dbg = 1'b0; m_waited = 0; m_beats = 0; m_rv = 1'b0; m_rd = 32'h0;
            end else begin
                if (edg && !ifc.d_we) begin
                    m_rv = 1'b1;
                    m_rd = mdl_mem[ifc.d_addr[9:2]];
                end else begin
                    m_rv = 1'b0;
                end
                if (ewen) mdl_mem[eaddr[9:2]] = ewdata;
                if (!m_dbg) begin
                    if (edg && ifc.d_lock) begin
                        m_dbg = 1'b1; m_beats = 1;
                    end else if (ifc.d_req && !edg && m_waited == SL - 1) begin
                        m_dbg = 1'b1; m_beats = 0;
                    end
                end else begin
                    if (edg) m_beats++;
                    if (!ifc.d_req || (edg && !ifc.d_lock) || (edg && m_beats >= MB)) begin
                        m_dbg = 1'b0; m_beats = 0;
                    end
                end
                if (ifc.d_req && !edg) m_waited = (m_waited < SL) ? m_waited + 1 : SL;
                else m_waited = 0;
            end
        end
    end

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic rn, input logic pr, input logic [31:0] pa, input logic [31:0] pw,
                       input logic pwe, input logic dr, input logic [31:0] da, input logic [31:0] dw,
                       input logic dwe, input logic dl);
        @(posedge clk);
        #1;
        rst_n = rn;
        ifc.p_req = pr; ifc.p_addr = pa; ifc.p_wdata = pw; ifc.p_we = pwe;
        ifc.d_req = dr; ifc.d_addr = da; ifc.d_wdata = dw; ifc.d_we = dwe; ifc.d_lock = dl;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0;
            mdl_mem[i] = 32'h0;
        end
        mem_arr[32] = 32'h1234_5678;
        mdl_mem[32] = 32'h1234_5678;
        rst_n = 1'b0;
        ifc.p_req = 1'b0; ifc.p_addr = 32'h0; ifc.p_wdata = 32'h0; ifc.p_we = 1'b0;
        ifc.d_req = 1'b0; ifc.d_addr = 32'h0; ifc.d_wdata = 32'h0; ifc.d_we = 1'b0; ifc.d_lock = 1'b0;
        started = 1'b1;

        // Reset behaviour
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_p_gnt", {31'b0, ifc.p_gnt}, 32'd0);
        chk("rst_d_gnt", {31'b0, ifc.d_gnt}, 32'd0);
        chk("rst_mem_wen", {31'b0, ifc.mem_wen}, 32'd0);
        chk("rst_p_stall", {31'b0, ifc.p_stall}, 32'd0);
        chk("rst_d_rvalid", {31'b0, ifc.d_rvalid}, 32'd0);
        chk("rst_d_rdata", ifc.d_rdata, 32'd0);
        cyc(1'b0, 1'b1, 32'h40, 32'h11, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_req_stall", {31'b0, ifc.p_stall}, 32'd1);
        chk("rst_req_wen", {31'b0, ifc.mem_wen}, 32'd0);

        // Pipeline store then load
        cyc(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("st_p_gnt", {31'b0, ifc.p_gnt}, 32'd1);
        chk("st_wen", {31'b0, ifc.mem_wen}, 32'd1);
        chk("st_stall", {31'b0, ifc.p_stall}, 32'd0);
        cyc(1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("ld_p_gnt", {31'b0, ifc.p_gnt}, 32'd1);
        chk("ld_p_rdata", ifc.p_rdata, 32'hDEAD_BEEF);
        chk("ld_stall", {31'b0, ifc.p_stall}, 32'd0);

        // Contention: debug wins every fifth cycle
        for (int c = 1; c <= 12; c++) begin
            logic [31:0] dg;
            cyc(1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0);
            dg = (c % 5 == 0) ? 32'd1 : 32'd0;
            chk($sformatf("cont%0d_d_gnt", c), {31'b0, ifc.d_gnt}, dg);
            chk($sformatf("cont%0d_p_gnt", c), {31'b0, ifc.p_gnt}, 32'd1 - dg);
            chk($sformatf("cont%0d_stall", c), {31'b0, ifc.p_stall}, dg);
        end
        idle();

        // Locked debug write burst with pipeline waiting from beat 2
        for (int b = 1; b <= 9; b++) begin
            cyc(1'b1, (b > 1) ? 1'b1 : 1'b0, 32'h44, 32'h0, 1'b0,
                1'b1, 32'h100 + 32'(4 * b), 32'hA000_0000 + 32'(b), 1'b1, 1'b1);
            chk($sformatf("burst%0d_d_gnt", b), {31'b0, ifc.d_gnt}, (b <= 8) ? 32'd1 : 32'd0);
            chk($sformatf("burst%0d_stall", b), {31'b0, ifc.p_stall}, (b >= 2 && b <= 8) ? 32'd1 : 32'd0);
            if (b == 9) chk("burst_p_gnt", {31'b0, ifc.p_gnt}, 32'd1);
        end
        idle();

        // Debug read of preloaded word
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 1'b0);
        chk("drd_gnt", {31'b0, ifc.d_gnt}, 32'd1);
        idle();
        chk("drd_rvalid", {31'b0, ifc.d_rvalid}, 32'd1);
        chk("drd_rdata", ifc.d_rdata, 32'h1234_5678);
        idle();
        chk("drd_rvalid_drop", {31'b0, ifc.d_rvalid}, 32'd0);

        // Reset during beat 3 of a locked write burst
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h1, 1'b1, 1'b1);
        chk("rb1_gnt", {31'b0, ifc.d_gnt}, 32'd1);
        chk("rb1_wen", {31'b0, ifc.mem_wen}, 32'd1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h2, 1'b1, 1'b1);
        chk("rb2_gnt", {31'b0, ifc.d_gnt}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h204, 32'h3, 1'b1, 1'b1);
        chk("rb3_gnt", {31'b0, ifc.d_gnt}, 32'd0);
        chk("rb3_wen", {31'b0, ifc.mem_wen}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0, 1'b0);
        chk("rb_after_gnt", {31'b0, ifc.d_gnt}, 32'd1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
        chk("rb_204_rvalid", {31'b0, ifc.d_rvalid}, 32'd1);
        chk("rb_204_rdata", ifc.d_rdata, 32'h0);
        idle();
        chk("rb_200_rdata", ifc.d_rdata, 32'h2);

        // Mixed traffic, checked by the reference model only
        for (int i = 0; i < 40; i++) begin
            logic [4:0] v;
            v = 5'(i * 7 + 3);
            cyc(1'b1, v[0] | v[2], 32'h300 + 32'(4 * (i % 4)), 32'hC0DE_0000 + 32'(i), v[3],
                v[1] | v[2], 32'h300 + 32'(4 * (i % 3)), 32'hD00D_0000 + 32'(i), v[4], v[2] | v[3]);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
